// File: rtl/noise_scheduler.sv
// Round-robin scheduler sharing one external noise LFSR across NCH voices, each with its own period divider.
// Optional feature: define NOISE_SCHED_OVERRUN_EN to get sticky per-voice dropped-tick flags on `overrun`.
module noise_scheduler #(
    parameter int NCH     = 4,
    parameter int DIVBITS = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH*DIVBITS-1:0]   period,
    input  logic [NCH-1:0]           ch_enable,
    input  logic                     lfsr_bit,
    output logic                     lfsr_shift,
    output logic [$clog2(NCH)-1:0]   gnt_ch,
    output logic [NCH-1:0]           noise_out,
    output logic                     busy,
    output logic [NCH-1:0]           overrun
);

    localparam int CHW = $clog2(NCH);

    logic [DIVBITS-1:0] cnt_q [NCH];
    logic [DIVBITS-1:0] cnt_d [NCH];
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     grant_vec;
    logic [NCH-1:0]     pend_q, pend_d;
    logic [CHW-1:0]     ptr_q, ptr_d;
    logic [CHW-1:0]     win;
    logic               found;
    int                 idx;
    logic               lfsr_shift_q, lfsr_shift_d;
    logic [CHW-1:0]     gnt_ch_q, gnt_ch_d;
    logic               cap_vld_q, cap_vld_d;
    logic [CHW-1:0]     cap_ch_q, cap_ch_d;
    logic [NCH-1:0]     noise_q, noise_d;

    // Round-robin search starting at the pointer, wrapping modulo NCH.
    always_comb begin
        found     = 1'b0;
        win       = ptr_q;
        idx       = 0;
        grant_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = CHW'(idx);
            end
        end
        if (found) begin
            grant_vec[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        lfsr_shift_d = found;
        gnt_ch_d     = gnt_ch_q;
        if (found) begin
            gnt_ch_d = win;
            ptr_d    = (int'(win) == NCH - 1) ? '0 : CHW'(int'(win) + 1);
        end
        cap_vld_d = lfsr_shift_q;
        cap_ch_d  = gnt_ch_q;
    end

    // Per-voice divider, pending flag and noise capture.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tick[i]    = ch_enable[i] && (cnt_q[i] == '0);
            cnt_d[i]   = (!ch_enable[i] || tick[i]) ? period[i*DIVBITS +: DIVBITS]
                                                    : cnt_q[i] - DIVBITS'(1);
            // A tick coinciding with the grant re-arms the request.
            pend_d[i]  = ch_enable[i] & (tick[i] | (pend_q[i] & ~grant_vec[i]));
            noise_d[i] = noise_q[i];
            if (!ch_enable[i]) begin
                noise_d[i] = 1'b0;
            end else if (cap_vld_q && (cap_ch_q == CHW'(i))) begin
                noise_d[i] = lfsr_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q       <= '0;
            ptr_q        <= '0;
            lfsr_shift_q <= 1'b0;
            gnt_ch_q     <= '0;
            cap_vld_q    <= 1'b0;
            cap_ch_q     <= '0;
            noise_q      <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            lfsr_shift_q <= lfsr_shift_d;
            gnt_ch_q     <= gnt_ch_d;
            cap_vld_q    <= cap_vld_d;
            cap_ch_q     <= cap_ch_d;
            noise_q      <= noise_d;
        end
    end

`ifdef NOISE_SCHED_OVERRUN_EN
    logic [NCH-1:0] overrun_q, overrun_d;

    // A tick is lost when its request is still outstanding and not being served now.
    always_comb begin
        overrun_d = overrun_q | (tick & pend_q & ~grant_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = '0;
`endif

    assign lfsr_shift = lfsr_shift_q;
    assign gnt_ch     = gnt_ch_q;
    assign noise_out  = noise_q;
    assign busy       = (|pend_q) | lfsr_shift_q | cap_vld_q;

endmodule

// File: tb/tb_noise_scheduler.sv
// Scoreboard bench for noise_scheduler: directed scenarios push expected grants, a monitor checks grants and captures.
module tb_noise_scheduler;

    localparam int NCH     = 4;
    localparam int DIVBITS = 12;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NCH*DIVBITS-1:0] period = '0;
    logic [NCH-1:0]         ch_enable = '0;
    logic                   lfsr_bit;
    logic                   lfsr_shift;
    logic [1:0]             gnt_ch;
    logic [NCH-1:0]         noise_out;
    logic                   busy;
    logic [NCH-1:0]         overrun;

    noise_scheduler #(.NCH(NCH), .DIVBITS(DIVBITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .period     (period),
        .ch_enable  (ch_enable),
        .lfsr_bit   (lfsr_bit),
        .lfsr_shift (lfsr_shift),
        .gnt_ch     (gnt_ch),
        .noise_out  (noise_out),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Shared LFSR the scheduler drives, updating on the same edge it samples lfsr_shift.
    logic [15:0] lfsr_q;
    always @(posedge clk) begin
        if (reset) lfsr_q <= SEED;
        else if (lfsr_shift) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign lfsr_bit = lfsr_q[15];

    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    typedef struct { int cyc; int ch; } exp_t;
    typedef struct { int cyc; int ch; logic b; } nchk_t;
    exp_t  exp_q[$];
    nchk_t nq[$];
    logic [15:0] model;

    task automatic push(input int c, input int ch);
        exp_q.push_back('{c, ch});
    endtask

    // Monitor: pops the expected grant whenever a strobe appears, then checks the capture two cycles later.
    always @(negedge clk) begin
        if (reset) begin
            model = SEED;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("grant_missing_at_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (lfsr_shift) begin
                $display("grant cycle=%0d ch=%0d", cyc, gnt_ch);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    chk("grant_ch", int'(gnt_ch), exp_q[0].ch);
                    void'(exp_q.pop_front());
                end else begin
                    chk("grant_unexpected", 1, 0);
                end
                model = lfsr_next(model);
                nq.push_back('{cyc + 2, int'(gnt_ch), model[15]});
            end
            while (nq.size() > 0 && nq[0].cyc <= cyc) begin
                if (nq[0].cyc == cyc)
                    chk($sformatf("noise_out[%0d]", nq[0].ch), int'(noise_out[nq[0].ch]),
                        ch_enable[nq[0].ch] ? int'(nq[0].b) : 0);
                void'(nq.pop_front());
            end
        end
    end

    task automatic goto(input int n);
        for (int k = 0; k < 1000 && cyc < n; k++) begin
            @(posedge clk);
            #1;
        end
        chk("goto_reached", int'(cyc >= n), 1);
    endtask

    // Ends the previous scenario, checks reset values one edge after reset, then releases with new settings.
    task automatic start(input logic [NCH-1:0] en, input logic [NCH*DIVBITS-1:0] per);
        chk("queue_drained", exp_q.size(), 0);
        reset = 1'b1;
        exp_q.delete();
        nq.delete();
        @(posedge clk);
        #1;
        chk("rst_lfsr_shift", int'(lfsr_shift), 0);
        chk("rst_gnt_ch", int'(gnt_ch), 0);
        chk("rst_noise_out", int'(noise_out), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        ch_enable = en;
        period    = per;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single voice, period 3.
        start(4'b0001, {12'd0, 12'd0, 12'd0, 12'd3});
        push(2, 0); push(6, 0); push(10, 0); push(14, 0);
        goto(3);
        chk("busy_capture", int'(busy), 1);
        goto(4);
        chk("busy_idle", int'(busy), 0);
        goto(17);

        // Simultaneous requests, period 7 on all voices.
        start(4'b1111, {12'd7, 12'd7, 12'd7, 12'd7});
        for (int c = 0; c < 3; c++)
            for (int ch = 0; ch < 4; ch++) push(2 + 8 * c + ch, ch);
        goto(22);
        chk("overrun_none", int'(overrun), 0);
        goto(24);

        // Reset mid-operation with the pointer advanced, then first grant must be voice 0.
        start(4'b1111, {12'd7, 12'd7, 12'd7, 12'd7});
        push(2, 0); push(3, 1);
        goto(4);
        chk("busy_before_reset", int'(busy), 1);
        start(4'b1111, {12'd7, 12'd7, 12'd7, 12'd7});
        push(2, 0); push(3, 1); push(4, 2); push(5, 3);
        goto(8);

        // Round-robin fairness, period 0.
        start(4'b1111, '0);
        for (int c = 2; c <= 17; c++) push(c, (c - 2) % 4);
        goto(17);
`ifdef NOISE_SCHED_OVERRUN_EN
        chk("overrun_all", int'(overrun), 15);
`else
        chk("overrun_tied", int'(overrun), 0);
`endif
        goto(18);

        // Disable voice 1 during its strobe.
        start(4'b1111, {12'd7, 12'd7, 12'd7, 12'd7});
        push(2, 0); push(3, 1);
        goto(3);
        ch_enable = 4'b1101;
        push(4, 2); push(5, 3); push(10, 0); push(11, 2); push(12, 3);
        goto(4);
        chk("disabled_noise1", int'(noise_out[1]), 0);
        goto(15);

        // Period change 3 -> 9 while running.
        start(4'b0001, {12'd0, 12'd0, 12'd0, 12'd3});
        push(2, 0); push(6, 0); push(10, 0); push(20, 0); push(30, 0);
        goto(5);
        period[0 +: DIVBITS] = 12'd9;
        goto(33);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
